// File: rtl/mac_pkg.sv
// Shared defaults and elaboration-time helpers for the read-side packing logic.
package mac_pkg;

  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_LANES = 4;

  // Ceiling log2. It is evaluated while parameters are elaborated.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pack_idle_timer.sv
// Idle timer for fifo_rd_pack. It is built only when PACK_TIMEOUT_EN is defined.
// It counts the clocks in which a partial word waits and no entry is popped.
// On the clock that would reach TIMEOUT it produces a one-cycle timeout strobe.
module pack_idle_timer
  import mac_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic rclk,
  input  logic rrst,
  input  logic cnt_nz,
  input  logic pop,
  output logic timeout_c
);

  localparam int unsigned     TW    = clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   LIMIT = TW'(TIMEOUT);
  localparam logic [TW-1:0]   FIRE  = TW'(TIMEOUT - 1);

  logic [TW-1:0] idle;
  logic          inc_c;

  // Count only while a partial word is waiting. Fire on the step that reaches TIMEOUT.
  always_comb begin
    inc_c     = 1'b0;
    timeout_c = 1'b0;
    inc_c     = cnt_nz && !pop;
    timeout_c = inc_c && (idle == FIRE);
  end

  // Idle counter: cleared by a pop, by an empty accumulator or by firing. It saturates at TIMEOUT.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      idle <= '0;
    end else if (!inc_c || timeout_c) begin
      idle <= '0;
    end else if (idle != LIMIT) begin
      idle <= idle + TW'(1);
    end
  end

endmodule

// File: rtl/fifo_rd_pack.sv
// fifo_rd_pack: read-side consumer of the async FIFO.
// It packs LANES show-ahead entries into one valid/ready word with a keep mask.
// Optional feature: define PACK_TIMEOUT_EN to flush a partial word automatically after
// TIMEOUT idle clocks.
module fifo_rd_pack
  import mac_pkg::*;
#(
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned LANES   = DEF_LANES,
  parameter int unsigned CW      = clog2(LANES) + 1,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                fifo_rempty,
  input  logic [DW-1:0]       fifo_rdata,
  output logic                fifo_rd,
  input  logic                flush,
  output logic                out_valid,
  output logic [DW*LANES-1:0] out_data,
  output logic [LANES-1:0]    out_keep,
  input  logic                out_ready
);

  localparam int unsigned   WW   = DW * LANES;
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  logic [CW-1:0]    cnt;
  logic             flush_pend;
  logic [WW-1:0]    acc;
  logic             timeout_c;

  logic             out_free_c;
  logic             pop_c;
  logic             cnt_nz_c;
  logic             full_load_c;
  logic             flush_done_c;
  logic             flush_emit_c;
  logic [WW-1:0]    acc_nxt_c;
  logic [WW-1:0]    part_data_c;
  logic [LANES-1:0] part_keep_c;

  // Pop decision, lane write-back and the zero-filled view of a partial word.
  always_comb begin
    out_free_c   = 1'b0;
    pop_c        = 1'b0;
    cnt_nz_c     = 1'b0;
    full_load_c  = 1'b0;
    flush_done_c = 1'b0;
    flush_emit_c = 1'b0;
    acc_nxt_c    = acc;
    part_data_c  = '0;
    part_keep_c  = '0;

    out_free_c   = !out_valid || out_ready;
    cnt_nz_c     = (cnt != '0);
    pop_c        = !rrst && !fifo_rempty && !flush_pend && ((cnt < LAST) || out_free_c);
    full_load_c  = pop_c && (cnt == LAST);
    flush_done_c = !rrst && flush_pend && out_free_c;
    flush_emit_c = flush_done_c && cnt_nz_c;

    for (int unsigned i = 0; i < LANES; i++) begin
      if (pop_c && (cnt == CW'(i))) acc_nxt_c[i*DW +: DW] = fifo_rdata;
      if (CW'(i) < cnt) begin
        part_data_c[i*DW +: DW] = acc[i*DW +: DW];
        part_keep_c[i]          = 1'b1;
      end
    end
  end

  assign fifo_rd = pop_c;

  // Accumulator, lane count and pending-flush state.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      acc <= acc_nxt_c;
      if (full_load_c || flush_done_c) begin
        cnt <= '0;
      end else if (pop_c) begin
        cnt <= cnt + CW'(1);
      end
      flush_pend <= flush_done_c ? 1'b0 : (flush_pend | flush | timeout_c);
    end
  end

  // Output register. It loads a full or a flushed word and holds it under backpressure.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
    end else if (full_load_c) begin
      out_data  <= {fifo_rdata, acc[WW-DW-1:0]};
      out_keep  <= '1;
      out_valid <= 1'b1;
    end else if (flush_emit_c) begin
      out_data  <= part_data_c;
      out_keep  <= part_keep_c;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef PACK_TIMEOUT_EN
  pack_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .rclk      (rclk),
    .rrst      (rrst),
    .cnt_nz    (cnt_nz_c),
    .pop       (pop_c),
    .timeout_c (timeout_c)
  );
`else
  // No auto-flush. TIMEOUT has no effect in this build.
  assign timeout_c = 1'b0 & (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_fifo_rd_pack.sv
// Bench for fifo_rd_pack: queue-based packing model checked every cycle, plus directed scenarios.
module tb_fifo_rd_pack;

  localparam int unsigned DW      = 8;
  localparam int unsigned LANES   = 4;
  localparam int unsigned CW      = 3;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned WW      = DW * LANES;

  logic             rclk = 1'b0;
  logic             rrst = 1'b1;
  logic             fifo_rempty = 1'b1;
  logic [DW-1:0]    fifo_rdata = '0;
  logic             fifo_rd;
  logic             flush = 1'b0;
  logic             out_valid;
  logic [WW-1:0]    out_data;
  logic [LANES-1:0] out_keep;
  logic             out_ready = 1'b0;

  always #5 rclk = ~rclk;

  fifo_rd_pack #(
    .DW(DW), .LANES(LANES), .CW(CW), .TIMEOUT(TIMEOUT)
  ) dut (
    .rclk        (rclk),
    .rrst        (rrst),
    .fifo_rempty (fifo_rempty),
    .fifo_rdata  (fifo_rdata),
    .fifo_rd     (fifo_rd),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_keep    (out_keep),
    .out_ready   (out_ready)
  );

  typedef struct {
    logic [WW-1:0]    data;
    logic [LANES-1:0] keep;
    int               at;
  } word_t;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int pops   = 0;

  logic [DW-1:0]    fq[$];
  logic [DW-1:0]    part[$];
  bit               m_fp = 1'b0;
  bit               m_valid = 1'b0;
  logic [WW-1:0]    m_data = '0;
  logic [LANES-1:0] m_keep = '0;
  int               m_idle = 0;
  bit               m_loaded;
  word_t            dut_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
    end
  endtask

  // Model: move the gathered entries into the expected output word (lane 0 = oldest).
  task automatic emit_word();
    m_data = '0;
    for (int i = 0; i < part.size(); i++) m_data[i*DW +: DW] = part[i];
    m_keep   = LANES'((1 << part.size()) - 1);
    m_valid  = 1'b1;
    m_loaded = 1'b1;
    part.delete();
  endtask

  // One clock: check the registered outputs, drive the inputs, check fifo_rd and advance the model.
  task automatic cyc(input logic r, input logic f, input logic rdy);
    bit exp_pop, free, handled, tmo;
    int n;
    @(negedge rclk);
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("out_data", 64'(out_data), 64'(m_data));
      chk("out_keep", 64'(out_keep), 64'(m_keep));
    end
    rrst        = r;
    flush       = f;
    out_ready   = rdy;
    fifo_rempty = (fq.size() == 0);
    fifo_rdata  = (fq.size() > 0) ? fq[0] : DW'($urandom);
    #1;
    if (out_valid && out_ready) dut_log.push_back('{data: out_data, keep: out_keep, at: cyc_n});
    if (fifo_rd) pops++;
    if (r) begin
      exp_pop = 1'b0;
      chk("fifo_rd", 64'(fifo_rd), 64'(exp_pop));
      part.delete();
      m_fp = 1'b0; m_valid = 1'b0; m_data = '0; m_keep = '0; m_idle = 0;
    end else begin
      n       = part.size();
      free    = !m_valid || rdy;
      exp_pop = (fq.size() > 0) && !m_fp && ((n < LANES - 1) || free);
      handled = m_fp && free;
      chk("fifo_rd", 64'(fifo_rd), 64'(exp_pop));
      tmo = 1'b0;
`ifdef PACK_TIMEOUT_EN
      if (n == 0 || exp_pop) m_idle = 0;
      else if (m_idle == TIMEOUT - 1) begin tmo = 1'b1; m_idle = 0; end
      else m_idle++;
`endif
      m_loaded = 1'b0;
      if (exp_pop) begin
        part.push_back(fq[0]);
        if (part.size() == LANES) emit_word();
      end else if (handled && n > 0) begin
        emit_word();
      end
      if (!m_loaded && rdy) m_valid = 1'b0;
      m_fp = handled ? 1'b0 : (m_fp || f || tmo);
    end
    if (fifo_rd && fq.size() > 0) void'(fq.pop_front());
    cyc_n++;
  endtask

  task automatic chk_word(input string name, input int idx, input logic [WW-1:0] d,
                          input logic [LANES-1:0] k);
    checks++;
    if (idx >= dut_log.size()) begin
      errors++;
      $display("FAIL %s: word %0d never accepted, got %0d words", name, idx, dut_log.size());
    end else if (dut_log[idx].data !== d || dut_log[idx].keep !== k) begin
      errors++;
      $display("FAIL %s: got data %0h keep %0h expected data %0h keep %0h", name,
               dut_log[idx].data, dut_log[idx].keep, d, k);
    end
  endtask

  initial begin
    int l0, p0, c0;
    // Reset held for 3 clocks while the FIFO is not empty.
    fq.push_back(8'hE1); fq.push_back(8'hE2); fq.push_back(8'hE3);
    repeat (3) cyc(1'b1, 1'b0, 1'b1);
    chk("rst_fifo_rd", 64'(fifo_rd), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_keep", 64'(out_keep), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    fq.delete();

    // Stream with no backpressure.
    for (int i = 1; i <= 8; i++) fq.push_back(DW'(i * 17));
    l0 = dut_log.size(); p0 = pops; c0 = cyc_n;
    repeat (8) cyc(1'b0, 1'b0, 1'b1);
    chk("stream_pops", 64'(pops - p0), 64'd8);
    repeat (4) cyc(1'b0, 1'b0, 1'b1);
    chk("stream_count", 64'(dut_log.size() - l0), 64'd2);
    chk_word("stream_w0", l0, 32'h44332211, 4'hF);
    chk_word("stream_w1", l0 + 1, 32'h88776655, 4'hF);
    if (dut_log.size() >= l0 + 2) begin
      chk("stream_w0_at", 64'(dut_log[l0].at - c0), 64'd4);
      chk("stream_gap", 64'(dut_log[l0 + 1].at - dut_log[l0].at), 64'd4);
    end

    // Backpressure.
    for (int i = 1; i <= 8; i++) fq.push_back(DW'(i));
    l0 = dut_log.size(); p0 = pops;
    repeat (10) cyc(1'b0, 1'b0, 1'b0);
    chk("bp_pops", 64'(pops - p0), 64'd7);
    chk("bp_stall_rd", 64'(fifo_rd), 64'd0);
    chk("bp_hold_data", 64'(out_data), 64'h04030201);
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    repeat (6) cyc(1'b0, 1'b0, 1'b1);
    chk("bp_count", 64'(dut_log.size() - l0), 64'd2);
    chk_word("bp_w0", l0, 32'h04030201, 4'hF);
    chk_word("bp_w1", l0 + 1, 32'h08070605, 4'hF);

    // Flush of a partial word, then a flush with nothing gathered.
    fq.push_back(8'hA1); fq.push_back(8'hA2);
    l0 = dut_log.size();
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b1);
    chk("flush_count", 64'(dut_log.size() - l0), 64'd1);
    chk_word("flush_w", l0, 32'h0000A2A1, 4'h3);
    l0 = dut_log.size();
    cyc(1'b0, 1'b1, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b1);
    chk("flush_empty_count", 64'(dut_log.size() - l0), 64'd0);

    // Flush in the same clock as the pop that completes a word.
    fq.push_back(8'hB1); fq.push_back(8'hB2); fq.push_back(8'hB3); fq.push_back(8'hB4);
    l0 = dut_log.size();
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    repeat (6) cyc(1'b0, 1'b0, 1'b1);
    chk("flush_pop_count", 64'(dut_log.size() - l0), 64'd1);
    chk_word("flush_pop_w", l0, 32'hB4B3B2B1, 4'hF);

    // One entry and then an idle FIFO.
    fq.push_back(8'hC1);
    l0 = dut_log.size(); c0 = cyc_n;
    repeat (23) cyc(1'b0, 1'b0, 1'b1);
`ifdef PACK_TIMEOUT_EN
    chk("timeout_count", 64'(dut_log.size() - l0), 64'd1);
    chk_word("timeout_w", l0, 32'h000000C1, 4'h1);
    if (dut_log.size() > l0) chk("timeout_at", 64'(dut_log[l0].at - c0), 64'd18);
`else
    chk("no_timeout_count", 64'(dut_log.size() - l0), 64'd0);
    cyc(1'b0, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    chk_word("late_flush_w", l0, 32'h000000C1, 4'h1);
`endif

    // Random traffic: pushes, flushes, backpressure and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) < 6 && fq.size() < 16) fq.push_back(DW'($urandom));
      cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
